// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: result width, select
// encodings, queue entry layout and small helpers used by the result queue.
package alu_pkg;

    localparam int RESULT_W = 16;
    localparam int ENTRY_W  = RESULT_W + 3;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_RSV = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic [1:0]          sel;
        logic                flag;
        logic [RESULT_W-1:0] result;
    } alu_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_result_mem.sv
// Entry storage for the result queue: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module alu_result_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_queue.sv
// Registered output stage behind the ALU: small show-ahead FIFO of
// {sel, flag, result} with valid/ready handshakes and a saturating flag count.
module alu_result_queue #(
    parameter int DEPTH    = 4,
    parameter int RESULT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RESULT_W-1:0]        in_result,
    input  logic                       in_flag,
    input  logic [1:0]                 in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RESULT_W-1:0]        out_result,
    output logic                       out_flag,
    output logic [1:0]                 out_sel,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 flag_count
);

    import alu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = RESULT_W + 3;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic [7:0]    flag_count_q;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] rd_entry;
    occ_e          occ;
    logic          push;
    logic          pop;

    always_comb begin
        occ = OCC_PARTIAL;
        if (count_q == '0) begin
            occ = OCC_EMPTY;
        end else if (count_q == FULL_CNT) begin
            occ = OCC_FULL;
        end
    end

    // in_ready ignores out_ready on purpose: a full queue never accepts a push,
    // even in a cycle where the head is being consumed.
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            flag_count_q <= '0;
        end else begin
            count_q <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && in_flag) begin
                flag_count_q <= sat_inc8(flag_count_q);
            end
        end
    end

    assign wr_entry = {in_sel, in_flag, in_result};

    alu_result_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Head fields are masked so stale memory never leaks onto an idle bus.
    assign out_result = out_valid ? rd_entry[RESULT_W-1:0] : '0;
    assign out_flag   = out_valid & rd_entry[RESULT_W];
    assign out_sel    = out_valid ? rd_entry[RESULT_W+2:RESULT_W+1] : 2'b00;

    assign count      = count_q;
    assign flag_count = flag_count_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: a reference queue tracks expected
// entries, occupancy and flag count, and every cycle's outputs are compared.
module tb_alu_result_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_flag;
    logic [1:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_flag;
    logic [1:0]  out_sel;
    logic [2:0]  count;
    logic [7:0]  flag_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] sb[$];
    int          mfc = 0;

    alu_result_queue #(.DEPTH(4), .RESULT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flag    (in_flag),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flag   (out_flag),
        .out_sel    (out_sel),
        .count      (count),
        .flag_count (flag_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs, compare outputs against the model before
    // the edge, then advance the model by the handshakes the model predicts.
    task automatic step(input logic v, input logic [15:0] r, input logic f,
                        input logic [1:0] s, input logic rdy);
        logic [18:0] head;
        bit          push_m;
        bit          pop_m;
        in_valid  = v;
        in_result = r;
        in_flag   = f;
        in_sel    = s;
        out_ready = rdy;
        #1;
        head = (sb.size() != 0) ? sb[0] : 19'd0;
        check("in_ready",   32'(in_ready),   32'(sb.size() != 4));
        check("out_valid",  32'(out_valid),  32'(sb.size() != 0));
        check("count",      32'(count),      32'(sb.size()));
        check("out_result", 32'(out_result), 32'(head[15:0]));
        check("out_flag",   32'(out_flag),   32'(head[16]));
        check("out_sel",    32'(out_sel),    32'(head[18:17]));
        check("flag_count", 32'(flag_count), 32'(mfc));
        push_m = v && (sb.size() != 4);
        pop_m  = rdy && (sb.size() != 0);
        if (pop_m) void'(sb.pop_front());
        if (push_m) begin
            sb.push_back({s, f, r});
            if (f && mfc < 255) mfc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0, 1'b0, 2'b00, rdy);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_flag   = 1'b0;
        in_sel    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",    32'(count),     32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_out_valid",32'(out_valid), 32'd0);
        rst = 1'b0;

        // Idle after reset, then a single entry in and out.
        idle(1'b0);
        step(1'b1, 16'h00FF, 1'b0, 2'b00, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full, refuse a fifth push, drain in order.
        step(1'b1, 16'h0001, 1'b0, 2'b00, 1'b0);
        step(1'b1, 16'h54AB, 1'b1, 2'b01, 1'b0);
        step(1'b1, 16'hFE01, 1'b0, 2'b10, 1'b0);
        step(1'b1, 16'h0002, 1'b1, 2'b11, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 2'b00, 1'b0);
        check("full_count", 32'(count), 32'd4);
        repeat (5) idle(1'b1);

        // Full with push and pop together: pop only, push lands next cycle.
        step(1'b1, 16'hAAAA, 1'b0, 2'b00, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 2'b01, 1'b0);
        step(1'b1, 16'hCCCC, 1'b1, 2'b10, 1'b0);
        step(1'b1, 16'hDDDD, 1'b0, 2'b11, 1'b0);
        step(1'b1, 16'hABCD, 1'b1, 2'b11, 1'b1);
        check("full_pp_count", 32'(count), 32'd3);
        step(1'b1, 16'hABCD, 1'b1, 2'b11, 1'b0);
        check("full_pp_refill", 32'(count), 32'd4);
        repeat (5) idle(1'b1);

        // Steady push+pop at count 2, pointers wrap several times.
        step(1'b1, 16'h1111, 1'b0, 2'b00, 1'b0);
        step(1'b1, 16'h2222, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom), 1'($urandom), 2'($urandom), 1'b1);
        end
        check("steady_count", 32'(count), 32'd2);
        repeat (3) idle(1'b1);

        // Flag counter saturation with an always-ready consumer.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 16'(i), 1'b1, 2'(i), 1'b1);
        end
        check("flag_sat", 32'(flag_count), 32'd255);

        // Asynchronous reset mid-stream, with a push held across the reset edge.
        step(1'b1, 16'h5555, 1'b1, 2'b01, 1'b0);
        step(1'b1, 16'h6666, 1'b0, 2'b10, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count",      32'(count),      32'd0);
        check("arst_flag_count", 32'(flag_count), 32'd0);
        check("arst_out_valid",  32'(out_valid),  32'd0);
        check("arst_out_result", 32'(out_result), 32'd0);
        check("arst_in_ready",   32'(in_ready),   32'd1);
        @(posedge clk);
        #1;
        check("arst_push_ignored", 32'(count), 32'd0);
        rst = 1'b0;
        sb.delete();
        mfc = 0;
        step(1'b1, 16'h7777, 1'b1, 2'b11, 1'b1);
        step(1'b1, 16'h8888, 1'b0, 2'b00, 1'b1);
        repeat (3) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
